// File: rtl/irq_pkg.sv
// Shared definitions for the irq_pending request-capture block.
package irq_pkg;

  localparam int OUT_SIZE_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } irq_state_t;

  // Number of request lines served by an encoder of the given index width.
  function automatic int in_size(input int out_size);
    return 1 << out_size;
  endfunction

endpackage

// File: rtl/irq_pending_if.sv
// Bus between irq_pending, its 16:1 encoder and the downstream grant consumer.
interface irq_pending_if #(
  parameter int OUT_SIZE = irq_pkg::OUT_SIZE_DEFAULT
);
  localparam int IN_SIZE = irq_pkg::in_size(OUT_SIZE);

  logic [IN_SIZE-1:0]  irq;
  logic [IN_SIZE-1:0]  mask;
  logic [IN_SIZE-1:0]  pend;
  logic                enc_en;
  logic [OUT_SIZE-1:0] enc_idx;
  logic                pend_any;

  // Grant handshake: a transfer happens on a rising edge where req_valid and
  // req_ready are both high. Once raised, req_valid and req_idx stay stable
  // until that transfer; req_ready may toggle freely and may depend on req_valid.
  logic                req_valid;
  logic [OUT_SIZE-1:0] req_idx;
  logic                req_ready;

  modport slave (
    input  irq, mask, enc_idx, req_ready,
    output pend, enc_en, req_valid, req_idx, pend_any
  );

  modport master (
    output irq, mask, enc_idx, req_ready,
    input  pend, enc_en, req_valid, req_idx, pend_any
  );

endinterface

// File: rtl/irq_edge.sv
// Vector rising-edge detector; the history register loads every cycle, reset included,
// so lines already high when reset releases never look like new edges.
module irq_edge #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] irq_q;

  always_ff @(posedge clk) begin
    irq_q <= in_i;
  end

  assign rise_o = in_i & ~irq_q;

endmodule

// File: rtl/irq_pending.sv
// Sticky pending capture in front of the priority encoder, with a registered
// grant offered over valid/ready; acceptance clears the granted bit.
module irq_pending
  import irq_pkg::*;
#(
  parameter int OUT_SIZE = OUT_SIZE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  irq_pending_if.slave  bus,
  output irq_state_t    state_o
);

  localparam int IN_SIZE = in_size(OUT_SIZE);

  logic [IN_SIZE-1:0]  rise;
  logic [IN_SIZE-1:0]  clr;
  logic [IN_SIZE-1:0]  pend;
  logic [IN_SIZE-1:0]  pending_q, pending_d;
  logic [OUT_SIZE-1:0] req_idx_q, req_idx_d;
  irq_state_t          state_q, state_d;
  logic                pend_any;
  logic                accept;
  logic                enc_en;
  logic                req_valid;

  irq_edge #(
    .WIDTH (IN_SIZE)
  ) u_edge (
    .clk    (clk),
    .in_i   (bus.irq),
    .rise_o (rise)
  );

  assign pend     = pending_q & ~bus.mask;
  assign pend_any = |pend;
  assign accept   = (state_q == OFFER) && bus.req_ready;

  // The clear uses the registered index, so a bit masked during the offer still clears;
  // OR-ing rise last lets a fresh edge survive a same-cycle clear.
  always_comb begin
    clr = '0;
    if (accept) begin
      clr[req_idx_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  always_comb begin
    state_d   = state_q;
    req_idx_d = req_idx_q;
    enc_en    = 1'b0;
    req_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        enc_en = pend_any;
        if (pend_any) begin
          req_idx_d = bus.enc_idx;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        req_valid = 1'b1;
        if (bus.req_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      req_idx_q <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      req_idx_q <= req_idx_d;
      state_q   <= state_d;
    end
  end

  assign bus.pend      = pend;
  assign bus.pend_any  = pend_any;
  assign bus.enc_en    = enc_en;
  assign bus.req_valid = req_valid;
  assign bus.req_idx   = req_idx_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_irq_pending.sv
// Directed bench for irq_pending with a cycle model, a grant scoreboard and literal checks.
module tb_irq_pending;
  import irq_pkg::*;

  localparam int OS = 4;
  localparam int IS = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_state_t state;
  irq_pending_if #(.OUT_SIZE(OS)) bus ();

  irq_pending #(.OUT_SIZE(OS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Stand-in for the 16:1 encoder: lowest set bit of pend.
  always_comb begin
    bus.enc_idx = '0;
    for (int i = IS - 1; i >= 0; i--) begin
      if (bus.pend[i]) bus.enc_idx = OS'(i);
    end
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OS-1:0] lowest(input logic [IS-1:0] v);
    for (int i = 0; i < IS; i++) begin
      if (v[i]) return OS'(i);
    end
    return '0;
  endfunction

  // ---------------- model ----------------
  logic [IS-1:0] m_pend;
  logic [IS-1:0] m_prev;
  logic          m_valid;
  logic [OS-1:0] m_idx;
  bit            live = 1'b0;
  logic [OS-1:0] exp_q[$];

  always @(posedge clk) begin
    logic [IS-1:0] rise;
    logic [IS-1:0] vis;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = '0;
      m_prev  = bus.irq;
      exp_q.delete();
      live    = 1'b1;
    end else begin
      rise   = bus.irq & ~m_prev;
      m_prev = bus.irq;
      vis    = m_pend & ~bus.mask;
      if (m_valid) begin
        if (bus.req_ready) begin
          m_pend[m_idx] = 1'b0;
          m_valid       = 1'b0;
        end
      end else if (vis != '0) begin
        m_idx   = lowest(vis);
        m_valid = 1'b1;
        exp_q.push_back(m_idx);
      end
      m_pend = m_pend | rise;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [IS-1:0] ep;
    if (live) begin
      ep = m_pend & ~bus.mask;
      chk("m_pend", bus.pend, ep);
      chk("m_pend_any", 16'(bus.pend_any), 16'(|ep));
      chk("m_enc_en", 16'(bus.enc_en), 16'(!m_valid && (|ep)));
      chk("m_req_valid", 16'(bus.req_valid), 16'(m_valid));
      chk("m_req_idx", 16'(bus.req_idx), 16'(m_idx));
      if (bus.req_valid && bus.req_ready) begin
        if (exp_q.size() == 0) chk("grant_unexpected", 16'd1, 16'd0);
        else chk("grant", 16'(bus.req_idx), 16'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic expect_offer(input string name, input logic [OS-1:0] idx);
    mid();
    chk({name, "_valid"}, 16'(bus.req_valid), 16'd1);
    chk({name, "_idx"}, 16'(bus.req_idx), 16'(idx));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.irq       = 16'h0001;
    bus.mask      = '0;
    bus.req_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;

    // Line high across reset release must not become pending.
    mid();
    chk("rst_state", 16'(state), 16'(IDLE));
    chk("rst_idx", 16'(bus.req_idx), 16'd0);
    for (int i = 0; i < 10; i++) begin
      chk("rel_pend", bus.pend, 16'h0000);
      chk("rel_valid", 16'(bus.req_valid), 16'd0);
      cyc();
      mid();
    end

    // Single request on bit 5.
    cyc();
    bus.irq = 16'h0000; bus.req_ready = 1'b1;
    cyc();
    bus.irq = 16'h0020;
    mid(); chk("s_t_pend", bus.pend, 16'h0000);
    cyc(); mid();
    chk("s_t1_pend", bus.pend, 16'h0020);
    chk("s_t1_enc_en", 16'(bus.enc_en), 16'd1);
    cyc(); expect_offer("s_t2", 4'd5);
    cyc(); mid();
    chk("s_t3_pend", bus.pend, 16'h0000);
    chk("s_t3_valid", 16'(bus.req_valid), 16'd0);

    // Bits 3 and 9 together.
    cyc();
    bus.irq = 16'h0228;
    cyc(); mid(); chk("o_t1_pend", bus.pend, 16'h0208);
    cyc(); expect_offer("o_t2", 4'd3);
    cyc(); mid();
    chk("o_t3_pend", bus.pend, 16'h0200);
    chk("o_t3_valid", 16'(bus.req_valid), 16'd0);
    cyc(); expect_offer("o_t4", 4'd9);
    cyc(); mid(); chk("o_t5_any", 16'(bus.pend_any), 16'd0);

    // Masked bit 3 waits behind bit 9.
    cyc();
    bus.irq = 16'h0000;
    cyc();
    bus.irq = 16'h0208; bus.mask = 16'h0008;
    cyc(); mid(); chk("k_t1_pend", bus.pend, 16'h0200);
    cyc(); expect_offer("k_t2", 4'd9);
    cyc();
    bus.mask = 16'h0000;
    mid();
    chk("k_t3_pend", bus.pend, 16'h0008);
    chk("k_t3_valid", 16'(bus.req_valid), 16'd0);
    cyc(); expect_offer("k_t4", 4'd3);
    cyc(); mid(); chk("k_t5_any", 16'(bus.pend_any), 16'd0);

    // Backpressure on 9, new edge on bit 0, mask 9 mid-offer.
    cyc();
    bus.irq = 16'h0000;
    cyc();
    bus.irq = 16'h0200; bus.req_ready = 1'b0;
    cyc(); mid(); chk("b_t1_pend", bus.pend, 16'h0200);
    cyc(); expect_offer("b_t2", 4'd9);
    cyc();
    bus.irq = 16'h0201;
    expect_offer("b_t3", 4'd9);
    cyc();
    bus.mask = 16'h0200;
    expect_offer("b_t4", 4'd9);
    cyc(); expect_offer("b_t5", 4'd9);
    cyc(); expect_offer("b_t6", 4'd9);
    cyc();
    bus.req_ready = 1'b1;
    expect_offer("b_t7", 4'd9);
    cyc();
    bus.mask = 16'h0000;
    mid();
    chk("b_t8_pend", bus.pend, 16'h0001);
    chk("b_t8_valid", 16'(bus.req_valid), 16'd0);
    cyc(); expect_offer("b_t9", 4'd0);
    cyc(); mid(); chk("b_t10_any", 16'(bus.pend_any), 16'd0);

    // New edge on 9 in its own accept cycle, then reset mid-offer.
    cyc();
    bus.irq = 16'h0000;
    cyc();
    bus.irq = 16'h0200;
    cyc();
    bus.irq = 16'h0000;
    mid(); chk("c_t1_pend", bus.pend, 16'h0200);
    cyc();
    bus.irq = 16'h0200;
    expect_offer("c_t2", 4'd9);
    cyc();
    bus.req_ready = 1'b0;
    mid();
    chk("c_t3_pend", bus.pend, 16'h0200);
    chk("c_t3_valid", 16'(bus.req_valid), 16'd0);
    cyc(); expect_offer("c_t4", 4'd9);
    cyc();
    rst = 1'b1;
    expect_offer("c_t5", 4'd9);
    cyc();
    rst = 1'b0;
    mid();
    chk("r_valid", 16'(bus.req_valid), 16'd0);
    chk("r_pend", bus.pend, 16'h0000);
    chk("r_idx", 16'(bus.req_idx), 16'd0);
    chk("r_state", 16'(state), 16'(IDLE));
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      chk("r_after_pend", bus.pend, 16'h0000);
    end

    cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending.md
# irq_pending

Request-capture front end that sits directly upstream of the 16:1 priority encoder (`encod`). It edge-detects raw request lines, holds them as sticky pending bits, and drives the masked pending vector and enable into the encoder. It registers the returned index and offers it downstream over a valid/ready handshake. Acceptance clears the serviced pending bit, so each request edge is granted exactly once.

## Interface
- `OUT_SIZE`, 4, index width; must match the encoder's `OUT_SIZE`.
- `IN_SIZE`, `1<<OUT_SIZE`, number of request lines.

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `irq` in IN_SIZE: raw request lines, synchronous to `clk`.
- `mask` in IN_SIZE: 1 = bit hidden from the encoder; capture continues while hidden.
- `pend` out IN_SIZE: `pending & ~mask`; drives encoder `in`.
- `enc_en` out 1: drives encoder `enable`.
- `enc_idx` in OUT_SIZE: encoder `enc_out`, combinational from `pend`.
- `req_valid` out 1: grant index offered.
- `req_idx` out OUT_SIZE: offered index.
- `req_ready` in 1: downstream accepts when high together with `req_valid`.
- `pend_any` out 1: `|pend`.

## Operation
- Edge detect:
  - `irq_q <= irq` every cycle, including during `rst`.
  - `rise = irq & ~irq_q`.
  - Lines already high at reset release never produce a pending bit.
- Pending register: `pending <= (pending & ~clr) | rise`.
  - `clr` is one-hot at `req_idx` on accept, else 0.
  - Set wins over clear when both hit the same bit in one cycle.
- The FSM has two states, IDLE and OFFER. Reset state is IDLE.
- IDLE:
  - `enc_en = pend_any`.
  - If `pend_any`, register `req_idx <= enc_idx` and go to OFFER. Otherwise stay in IDLE.
- OFFER:
  - `req_valid = 1` and `enc_en = 0`.
  - `req_idx` is held stable.
  - On `req_valid && req_ready`: clear `pending[req_idx]` and return to IDLE.
- An offer is never retracted. Masking or any change on `irq` during OFFER does not alter `req_valid` or `req_idx`.
- The accepted bit is cleared even if it is masked at the time of acceptance.
- Priority is inherited from the encoder: the lowest-numbered visible pending bit wins.
- The encoder output is ignored whenever `enc_en = 0`.

## Timing
- Reset values:
  - `pending = 0`; `pend = 0`.
  - `pend_any = 0`; `enc_en = 0`.
  - `req_valid = 0`; `req_idx = 0`.
  - State = IDLE.
  - `irq_q = irq` as sampled during reset.
- Edge-to-offer latency:
  - Edge sampled at end of cycle t.
  - `pend` bit visible in cycle t+1 (IDLE evaluates, `enc_idx` captured).
  - `req_valid` high in cycle t+2.
- Accept in cycle a:
  - Bit cleared and state IDLE in cycle a+1.
  - Next offer earliest in cycle a+2.
  - Throughput is at most one grant per 2 cycles.
- `rst` in any state, including mid-OFFER: all outputs take their reset values in the next cycle. In-flight offers and pending bits are discarded.
- `mask` is combinational into `pend` and `pend_any` in the same cycle.

## Structure
- Package `irq_pkg`:
  - `OUT_SIZE` default.
  - `IN_SIZE` derivation.
  - State enum `irq_state_t` {IDLE, OFFER}.
- Sub-module `irq_edge`: parameterised vector rising-edge detector holding `irq_q`; outputs `rise`; loads `irq_q` during reset.
- The top level instantiates `irq_edge`, the pending register, and the FSM. The encoder is instantiated by the parent alongside this block, not inside it.

## Test plan
- Reset release test:
  - Stimulus: hold `irq=16'h0001` through reset, release, run 10 cycles.
  - Required response: `pend=0` and `req_valid=0` throughout.
- Single-request latency test:
  - Stimulus: rising edge on `irq[5]` at cycle t, `req_ready=1`.
  - Required response: `pend=16'h0020` at t+1; `req_valid=1`, `req_idx=5` at t+2; `pend=0`, `req_valid=0` at t+3.
- Simultaneous-request ordering test:
  - Stimulus: bits 3 and 9 rise together, `req_ready=1`.
  - Required response: offers `req_idx=3` at t+2 and `req_idx=9` at t+4; then `pend_any=0`.
- Mask test:
  - Stimulus: bits 3 and 9 pending with `mask[3]=1`.
  - Required response: offer 9 first; after accept, clear `mask[3]` and 3 is offered 2 cycles later.
- Backpressure test:
  - Stimulus: `req_ready=0` for 5 cycles while offering 9; edge on bit 0 during the stall.
  - Required response: `req_idx` stays 9 throughout; after accept, 0 is offered.
- Set-over-clear and mid-offer reset test:
  - Stimulus: new edge on bit 9 in its accept cycle.
  - Required response: bit 9 stays pending and is re-offered.
  - Stimulus: `rst` asserted mid-OFFER.
  - Required response: `req_valid=0` and `pend=0` in the next cycle.
